// File: rtl/alu_nbit_seq_pkg.sv
// rtl/alu_nbit_seq_pkg.sv - opcodes and FSM state encoding for the sequential N-bit ALU
// Purpose: shared op-code constants and controller state type.
// Ports: none (package).
package alu_nbit_seq_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_nbit_seq_if.sv
// rtl/alu_nbit_seq_if.sv - operand/result handshake bundle for the sequential ALU
// Purpose: groups the request (a/b/op) and response (result/flags) handshakes.
// Ports (signals): in_valid/in_ready/a/b/op request side; out_valid/out_ready/result/zero/carry/overflow response side.
// master = operand producer and result consumer; slave = the ALU.
interface alu_nbit_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );

endinterface

// File: rtl/alu_nbit_seq_core.sv
// rtl/alu_nbit_seq_core.sv - combinational WIDTH-bit logic/add/sub/slt unit
// Purpose: single-cycle AND/OR/NAND/NOR/ADD/SUB/SLT with carry and signed overflow.
// Ports: a, b (WIDTH) operands; op (3) opcode; result (WIDTH); carry; overflow.
// Opcode 101 is evaluated as ADD here; the multiplier lives in the top.
module alu_nbit_seq_core
  import alu_nbit_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] low_sum;
  logic [WIDTH-1:0] sum;
  logic             c_msb;
  logic             c_out;
  logic             ovf;

  always_comb begin
    sub_mode = (op == OP_SUB) || (op == OP_SLT);
    // Subtraction is A + ~B + 1, so carry=1 means no borrow.
    b_eff    = sub_mode ? ~b : b;
    // Add the low WIDTH-1 bits separately to expose the carry into the MSB.
    low_sum  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
             + {{(WIDTH-1){1'b0}}, sub_mode};
    c_msb    = low_sum[WIDTH-1];
    {c_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    ovf      = c_msb ^ c_out;

    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_SLT: begin
        // Signed less-than: sign of the difference corrected by overflow.
        result   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        carry    = c_out;
        overflow = ovf;
      end
      default: begin
        result   = sum;
        carry    = c_out;
        overflow = ovf;
      end
    endcase
  end

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - N-bit ALU with valid/ready handshakes and shift-add multiply
// Purpose: registers single-cycle core results; runs an unsigned multi-cycle MUL.
// Ports: clk; rst (async, active-high); bus (alu_nbit_seq_if.slave): in_valid/in_ready/a/b/op,
//        out_valid/out_ready/result/zero/carry/overflow.
module alu_nbit_seq
  import alu_nbit_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_nbit_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               carry_q;
  logic               ovf_q;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               is_mul;
  logic [2:0]         core_op;
  logic [WIDTH-1:0]   core_result;
  logic               core_carry;
  logic               core_ovf;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               mul_last;

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_mul        = MUL_EN && (bus.op == OP_MUL);
  // With the multiplier disabled, opcode 101 falls back to ADD.
  assign core_op       = (bus.op == OP_MUL) ? OP_ADD : bus.op;

  assign acc_nxt       = acc + (mplier[0] ? mcand : '0);
  assign mul_last      = (cnt == CW'(WIDTH - 1));

  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

  alu_nbit_seq_core #(.WIDTH(WIDTH)) u_core (
    .a        (bus.a),
    .b        (bus.b),
    .op       (core_op),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        MUL: begin
          // One multiplier bit per cycle, LSB first.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            result_q <= acc_nxt[WIDTH-1:0];
            zero_q   <= (acc_nxt[WIDTH-1:0] == '0);
            carry_q  <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf_q    <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new transfer overrides the DONE->IDLE step so ops can stream back to back.
      if (accept) begin
        if (is_mul) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, bus.a};
          mplier <= bus.b;
          cnt    <= '0;
          state  <= MUL;
        end else begin
          result_q <= core_result;
          zero_q   <= (core_result == '0);
          carry_q  <= core_carry;
          ovf_q    <= core_ovf;
          state    <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - self-checking bench for alu_nbit_seq (WIDTH=8)
module tb_alu_nbit_seq;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  alu_nbit_seq_if #(.WIDTH(8)) bus ();

  alu_nbit_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_alu(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    exp_t        e;
    int          sx;
    int          sy;
    int          s;
    int unsigned u;
    sx = $signed(x);
    sy = $signed(y);
    e.res = 8'h00;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b011: e.res = ~(x & y);
      3'b100: e.res = ~(x | y);
      3'b010: begin
        u = x + y;
        e.res = u[7:0];
        e.c = (u > 255);
        s = sx + sy;
        e.v = (s > 127) || (s < -128);
      end
      3'b101: begin
        u = x * y;
        e.res = u[7:0];
        e.c = (u > 255);
      end
      default: begin
        u = x + (255 - y) + 1;
        e.c = (u > 255);
        s = sx - sy;
        e.v = (s > 127) || (s < -128);
        if (o == 3'b111) e.res = (sx < sy) ? 8'h01 : 8'h00;
        else e.res = u[7:0];
      end
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk8({tag, "_res"}, bus.result, e.res);
    chk1({tag, "_z"}, bus.zero, e.z);
    chk1({tag, "_c"}, bus.carry, e.c);
    chk1({tag, "_v"}, bus.overflow, e.v);
  endtask

  // Called at a negedge with the ALU idle; returns at a negedge with it idle again.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    exp_t e;
    int   lat;
    e = ref_alu(x, y, o);
    bus.a = x;
    bus.b = y;
    bus.op = o;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom();
    bus.b = $urandom();
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chki({tag, "_latency"}, lat, (o == 3'b101) ? 9 : 1);
    chk_out(tag, e);
    @(negedge clk);
    chk1({tag, "_consumed"}, bus.out_valid, 1'b0);
  endtask

  logic [2:0] ops [8];
  logic [2:0] sops [7];
  exp_t       sq [4];
  exp_t       bp;

  initial begin
    checks = 0;
    passed = 0;
    ops  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    sops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.op = 3'b000;

    // Reset state
    @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk8("rst_result", bus.result, 8'h00);
    chk1("rst_zero", bus.zero, 1'b0);
    chk1("rst_carry", bus.carry, 1'b0);
    chk1("rst_overflow", bus.overflow, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Boundary vectors
    run_op("add_ff_01", 8'hFF, 8'h01, 3'b010);
    run_op("sub_80_01", 8'h80, 8'h01, 3'b110);
    run_op("slt_80_01", 8'h80, 8'h01, 3'b111);
    run_op("mul_10_11", 8'h10, 8'h11, 3'b101);
    run_op("mul_05_03", 8'h05, 8'h03, 3'b101);
    run_op("add_7f_01", 8'h7F, 8'h01, 3'b010);
    run_op("mul_ff_ff", 8'hFF, 8'hFF, 3'b101);
    run_op("slt_01_80", 8'h01, 8'h80, 3'b111);

    // Random operands on every opcode
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        run_op($sformatf("rnd%0d_op%0d", r, k), 8'($urandom()), 8'($urandom()), ops[k]);
      end
    end

    // Backpressure: result held, new requests ignored
    bus.a = 8'hC3;
    bus.b = 8'h5A;
    bus.op = 3'b010;
    bp = ref_alu(8'hC3, 8'h5A, 3'b010);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 8'h11;
    bus.b = 8'h22;
    bus.op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("bp%0d_out_valid", i), bus.out_valid, 1'b1);
      chk1($sformatf("bp%0d_in_ready", i), bus.in_ready, 1'b0);
      chk_out($sformatf("bp%0d", i), bp);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_single", bus.out_valid, 1'b0);
    chk1("bp_release_in_ready", bus.in_ready, 1'b1);

    // Streaming: four 1-cycle ops back to back
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        chk1($sformatf("strm%0d_out_valid", i - 1), bus.out_valid, 1'b1);
        chk_out($sformatf("strm%0d", i - 1), sq[i-1]);
      end
      if (i < 4) begin
        bus.a = $urandom();
        bus.b = $urandom();
        bus.op = sops[$urandom_range(0, 6)];
        sq[i] = ref_alu(bus.a, bus.b, bus.op);
        bus.in_valid = 1'b1;
        chk1($sformatf("strm%0d_in_ready", i), bus.in_ready, 1'b1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk1("strm_drained", bus.out_valid, 1'b0);

    // Reset in the middle of a multiply
    bus.a = 8'h37;
    bus.b = 8'h9D;
    bus.op = 3'b101;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk8("midrst_result", bus.result, 8'h00);
    chk1("midrst_carry", bus.carry, 1'b0);
    chk1("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("postrst_out_valid", bus.out_valid, 1'b0);
    run_op("postrst_add", 8'h12, 8'h34, 3'b010);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
